bytecode_decoder: RTL and testbench

Consumer side of the fetch-to-decoder byte handshake. Accepts JVM bytecode bytes from the fetch state machine one at a time over `start_for_decoder`/`ready_from_decoder`. Gathers any immediate operand bytes, then classifies the instruction and extracts its index and constant. It holds `ready_from_decoder` low for an execution latency that depends on the instruction class, then reports the decoded instruction with a one-cycle valid pulse.

---
 rtl/bytecode_decoder.sv | 224 ++++++++++++++++++++++
 tb/tb_bytecode_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bytecode_decoder.sv
// bytecode_decoder
//   Consumer side of the fetch-to-decoder byte handshake. Takes one JVM
//   bytecode byte per transfer, collects up to two immediate operand bytes,
//   classifies the instruction, then stays busy (ready low) for a class
//   dependent latency and reports the decoded fields with a one-cycle
//   decode_valid pulse in the last busy cycle.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous, active-high reset
//   start_for_decoder   a byte is offered on data_for_decoder
//   data_for_decoder    offered byte (opcode or operand)
//   ready_from_decoder  decoder can accept a byte this cycle
//   decode_valid        one-cycle pulse, decoded outputs are new
//   opcode              opcode of the last decoded instruction
//   op_class            0 NOP,1 CONST,2 LOAD,3 STORE,4 STACK,5 ARITH,6 CONV,7 ILLEGAL
//   index               local-variable index (LOAD/STORE/iinc), else 0
//   const_value         signed constant (iconst/bipush/sipush/iinc), else 0
//   illegal             last decoded opcode is unsupported
module bytecode_decoder #(
   parameter int BYTE        = 8,
   parameter int MUL_LATENCY = 2,
   parameter int DIV_LATENCY = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_for_decoder,
   input  logic [BYTE-1:0]   data_for_decoder,
   output logic              ready_from_decoder,
   output logic              decode_valid,
   output logic [BYTE-1:0]   opcode,
   output logic [2:0]        op_class,
   output logic [BYTE-1:0]   index,
   output logic [2*BYTE-1:0] const_value,
   output logic              illegal
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_OPERAND = 2'd1;
   localparam logic [1:0] S_EXEC    = 2'd2;

   localparam logic [2:0] C_NOP   = 3'd0;
   localparam logic [2:0] C_CONST = 3'd1;
   localparam logic [2:0] C_LOAD  = 3'd2;
   localparam logic [2:0] C_STORE = 3'd3;
   localparam logic [2:0] C_STACK = 3'd4;
   localparam logic [2:0] C_ARITH = 3'd5;
   localparam logic [2:0] C_CONV  = 3'd6;
   localparam logic [2:0] C_ILL   = 3'd7;

   localparam int MAXL  = (DIV_LATENCY > MUL_LATENCY) ? DIV_LATENCY : MUL_LATENCY;
   localparam int CNT_W = $clog2(MAXL + 1);

   logic [1:0]        state;
   logic [BYTE-1:0]   op_r, b1_r;
   logic              got_b1;
   logic [CNT_W-1:0]  busy_cnt;

   // decoded fields held until the pulse for long-latency instructions
   logic [BYTE-1:0]   pend_op;
   logic [2:0]        pend_class;
   logic [BYTE-1:0]   pend_index;
   logic [2*BYTE-1:0] pend_const;
   logic              pend_ill;

   logic              xfer, final_xfer;
   logic [BYTE-1:0]   cur_op, cur_b1, cur_b2;
   logic [1:0]        n_ops;
   logic [CNT_W-1:0]  lat;
   logic [2:0]        cls;
   logic [BYTE-1:0]   idx;
   logic [2*BYTE-1:0] cv;

   assign ready_from_decoder = (state != S_EXEC);
   assign xfer = start_for_decoder & ready_from_decoder;

   // Assemble the instruction as it stands on the transfer edge so the
   // final byte can be decoded without first being registered.
   always_comb begin
      cur_op = (state == S_IDLE) ? data_for_decoder : op_r;
      cur_b1 = (state == S_OPERAND && !got_b1) ? data_for_decoder : b1_r;
      cur_b2 = data_for_decoder;
   end

   always_comb begin
      cls   = C_ILL;
      n_ops = 2'd0;
      lat   = CNT_W'(1);
      idx   = '0;
      cv    = '0;
      if (cur_op == 8'h00) begin
         cls = C_NOP;
      end else if (cur_op <= 8'h0F) begin
         cls = C_CONST;
         // iconst_m1..iconst_5 carry opcode-3
         if (cur_op >= 8'h02 && cur_op <= 8'h08)
            cv = {{BYTE{1'b0}}, cur_op} - 16'd3;
      end else if (cur_op == 8'h10) begin
         cls   = C_CONST;
         n_ops = 2'd1;
         cv    = {{BYTE{cur_b1[BYTE-1]}}, cur_b1};
      end else if (cur_op == 8'h11) begin
         cls   = C_CONST;
         n_ops = 2'd2;
         cv    = {cur_b1, cur_b2};
      end else if (cur_op >= 8'h15 && cur_op <= 8'h19) begin
         cls   = C_LOAD;
         n_ops = 2'd1;
         idx   = cur_b1;
      end else if (cur_op >= 8'h1A && cur_op <= 8'h35) begin
         cls = C_LOAD;
         // (opcode-0x1A)[1:0] only depends on the low two opcode bits
         if (cur_op <= 8'h2D)
            idx = {{(BYTE-2){1'b0}}, 2'(cur_op[1:0] - 2'd2)};
      end else if (cur_op >= 8'h36 && cur_op <= 8'h3A) begin
         cls   = C_STORE;
         n_ops = 2'd1;
         idx   = cur_b1;
      end else if (cur_op >= 8'h3B && cur_op <= 8'h56) begin
         cls = C_STORE;
         if (cur_op <= 8'h4E)
            idx = {{(BYTE-2){1'b0}}, 2'(cur_op[1:0] - 2'd3)};
      end else if (cur_op >= 8'h57 && cur_op <= 8'h5F) begin
         cls = C_STACK;
      end else if (cur_op >= 8'h60 && cur_op <= 8'h83) begin
         cls = C_ARITH;
         if (cur_op >= 8'h68 && cur_op <= 8'h6B)
            lat = CNT_W'(MUL_LATENCY);
         else if (cur_op >= 8'h6C && cur_op <= 8'h73)
            lat = CNT_W'(DIV_LATENCY);
      end else if (cur_op == 8'h84) begin
         cls   = C_ARITH;
         n_ops = 2'd2;
         idx   = cur_b1;
         cv    = {{BYTE{cur_b2[BYTE-1]}}, cur_b2};
      end else if (cur_op >= 8'h85 && cur_op <= 8'h93) begin
         cls = C_CONV;
      end
   end

   // At most two operands, so the second operand byte is always the last.
   always_comb begin
      final_xfer = 1'b0;
      if (xfer) begin
         if (state == S_IDLE)
            final_xfer = (n_ops == 2'd0);
         else if (state == S_OPERAND)
            final_xfer = got_b1 || (n_ops == 2'd1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         op_r         <= '0;
         b1_r         <= '0;
         got_b1       <= 1'b0;
         busy_cnt     <= '0;
         pend_op      <= '0;
         pend_class   <= '0;
         pend_index   <= '0;
         pend_const   <= '0;
         pend_ill     <= 1'b0;
         decode_valid <= 1'b0;
         opcode       <= '0;
         op_class     <= '0;
         index        <= '0;
         const_value  <= '0;
         illegal      <= 1'b0;
      end else begin
         decode_valid <= 1'b0;
         case (state)
            S_IDLE, S_OPERAND: begin
               if (xfer) begin
                  if (state == S_IDLE) begin
                     op_r   <= data_for_decoder;
                     got_b1 <= 1'b0;
                  end else if (!got_b1) begin
                     b1_r   <= data_for_decoder;
                     got_b1 <= 1'b1;
                  end
                  if (final_xfer) begin
                     state      <= S_EXEC;
                     busy_cnt   <= lat - CNT_W'(1);
                     pend_op    <= cur_op;
                     pend_class <= cls;
                     pend_index <= idx;
                     pend_const <= cv;
                     pend_ill   <= (cls == C_ILL);
                     // single-cycle latency: the pulse lands in the first busy cycle
                     if (lat == CNT_W'(1)) begin
                        decode_valid <= 1'b1;
                        opcode       <= cur_op;
                        op_class     <= cls;
                        index        <= idx;
                        const_value  <= cv;
                        illegal      <= (cls == C_ILL);
                     end
                  end else begin
                     state <= S_OPERAND;
                  end
               end
            end
            S_EXEC: begin
               if (busy_cnt == '0) begin
                  state <= S_IDLE;
               end else begin
                  busy_cnt <= busy_cnt - CNT_W'(1);
                  if (busy_cnt == CNT_W'(1)) begin
                     decode_valid <= 1'b1;
                     opcode       <= pend_op;
                     op_class     <= pend_class;
                     index        <= pend_index;
                     const_value  <= pend_const;
                     illegal      <= pend_ill;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bytecode_decoder.sv
module tb_bytecode_decoder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start_for_decoder = 1'b0;
   logic [7:0]  data_for_decoder = 8'h00;
   logic        ready_from_decoder;
   logic        decode_valid;
   logic [7:0]  opcode;
   logic [2:0]  op_class;
   logic [7:0]  index;
   logic [15:0] const_value;
   logic        illegal;

   int total = 0;
   int bad   = 0;

   bytecode_decoder #(.BYTE(8), .MUL_LATENCY(2), .DIV_LATENCY(4)) dut (
      .clk(clk), .reset(reset),
      .start_for_decoder(start_for_decoder), .data_for_decoder(data_for_decoder),
      .ready_from_decoder(ready_from_decoder), .decode_valid(decode_valid),
      .opcode(opcode), .op_class(op_class), .index(index),
      .const_value(const_value), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (straight from the opcode table) ----
   function automatic int n_ops(input int o);
      if (o == 'h10 || (o >= 'h15 && o <= 'h19) || (o >= 'h36 && o <= 'h3A)) return 1;
      if (o == 'h11 || o == 'h84) return 2;
      return 0;
   endfunction

   function automatic int sx(input int b);
      return (b > 127) ? b - 256 : b;
   endfunction

   function automatic void model(input int o, input int b1, input int b2,
                                 output int cls, output int idx, output int lat,
                                 output logic [15:0] cv);
      int v;
      cls = 7; idx = 0; lat = 1; v = 0;
      if (o == 0) cls = 0;
      else if (o <= 'h0F) begin cls = 1; if (o >= 2 && o <= 8) v = o - 3; end
      else if (o == 'h10) begin cls = 1; v = sx(b1); end
      else if (o == 'h11) begin cls = 1; v = b1 * 256 + b2; end
      else if (o >= 'h15 && o <= 'h19) begin cls = 2; idx = b1; end
      else if (o >= 'h1A && o <= 'h35) begin cls = 2; if (o <= 'h2D) idx = (o - 'h1A) % 4; end
      else if (o >= 'h36 && o <= 'h3A) begin cls = 3; idx = b1; end
      else if (o >= 'h3B && o <= 'h56) begin cls = 3; if (o <= 'h4E) idx = (o - 'h3B) % 4; end
      else if (o >= 'h57 && o <= 'h5F) cls = 4;
      else if (o >= 'h60 && o <= 'h83) begin
         cls = 5;
         if (o >= 'h68 && o <= 'h6B) lat = 2;
         if (o >= 'h6C && o <= 'h73) lat = 4;
      end
      else if (o == 'h84) begin cls = 5; idx = b1; v = sx(b2); end
      else if (o >= 'h85 && o <= 'h93) cls = 6;
      cv = 16'(v);
   endfunction

   // ---------------- stimulus helpers -----------------------------------
   // Called just after a rising edge; returns just after the accepting edge.
   task automatic offer(input logic [7:0] b);
      bit ok = 0;
      start_for_decoder = 1'b1;
      data_for_decoder  = b;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         if (ready_from_decoder === 1'b1) begin
            @(posedge clk); #1;
            ok = 1;
         end
      end
      start_for_decoder = 1'b0;
      if (!ok) begin
         total++; bad++;
         $display("FAIL offer_timeout byte=%02h ready stayed low", b);
      end
   endtask

   task automatic run_instr(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int gap, input bit hold_busy);
      logic [7:0]  bytes [3];
      logic [15:0] e_cv;
      int n, e_cls, e_idx, e_lat;
      bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
      n = n_ops(b0) + 1;
      model(b0, b1, b2, e_cls, e_idx, e_lat, e_cv);
      for (int i = 0; i < n; i++) begin
         if (gap > 0 && i > 0) begin
            repeat ($urandom_range(gap)) @(posedge clk);
            #1;
         end
         offer(bytes[i]);
      end
      if (hold_busy) begin
         start_for_decoder = 1'b1;
         data_for_decoder  = 8'h00;
      end
      for (int k = 1; k <= e_lat; k++) begin
         @(negedge clk);
         total++;
         if (ready_from_decoder !== 1'b0) begin
            bad++; $display("FAIL busy_ready op=%02h cyc=%0d got=%b want=0", b0, k, ready_from_decoder);
         end
         total++;
         if (decode_valid !== (k == e_lat)) begin
            bad++; $display("FAIL valid_timing op=%02h cyc=%0d got=%b want=%b", b0, k, decode_valid, k == e_lat);
         end
         if (k == e_lat) begin
            total++;
            if (opcode !== b0) begin
               bad++; $display("FAIL opcode got=%02h want=%02h", opcode, b0);
            end
            total++;
            if (op_class !== 3'(e_cls)) begin
               bad++; $display("FAIL op_class op=%02h got=%0d want=%0d", b0, op_class, e_cls);
            end
            total++;
            if (index !== 8'(e_idx)) begin
               bad++; $display("FAIL index op=%02h got=%0d want=%0d", b0, index, e_idx);
            end
            total++;
            if (const_value !== e_cv) begin
               bad++; $display("FAIL const_value op=%02h got=%04h want=%04h", b0, const_value, e_cv);
            end
            total++;
            if (illegal !== (e_cls == 7)) begin
               bad++; $display("FAIL illegal op=%02h got=%b want=%b", b0, illegal, e_cls == 7);
            end
         end
      end
      @(negedge clk);
      start_for_decoder = 1'b0;
      total++;
      if (ready_from_decoder !== 1'b1 || decode_valid !== 1'b0) begin
         bad++; $display("FAIL after_window op=%02h ready=%b valid=%b want ready=1 valid=0",
                         b0, ready_from_decoder, decode_valid);
      end
      @(posedge clk); #1;
      if (hold_busy) begin
         // a byte held during the busy window must not have been consumed
         @(negedge clk);
         total++;
         if (ready_from_decoder !== 1'b1 || decode_valid !== 1'b0) begin
            bad++; $display("FAIL held_byte_consumed op=%02h ready=%b valid=%b", b0, ready_from_decoder, decode_valid);
         end
         @(posedge clk); #1;
      end
   endtask

   // ---------------- scenarios ------------------------------------------
   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      total++;
      if (ready_from_decoder !== 1'b1 || decode_valid !== 1'b0) begin
         bad++; $display("FAIL reset_hs ready=%b valid=%b want 1/0", ready_from_decoder, decode_valid);
      end
      total++;
      if ({opcode, op_class, index, const_value, illegal} !== '0) begin
         bad++; $display("FAIL reset_outputs op=%02h cls=%0d idx=%0d cv=%04h ill=%b want all 0",
                         opcode, op_class, index, const_value, illegal);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_iconst;
      run_instr(8'h03, 8'h00, 8'h00, 0, 0);
      run_instr(8'h04, 8'h00, 8'h00, 0, 0);
      run_instr(8'h02, 8'h00, 8'h00, 0, 0);
   endtask

   task automatic test_div_latency;
      run_instr(8'h6F, 8'h00, 8'h00, 0, 1);
      run_instr(8'h68, 8'h00, 8'h00, 0, 1);
   endtask

   task automatic test_multibyte;
      run_instr(8'h11, 8'h80, 8'h01, 0, 0);
      run_instr(8'h84, 8'h05, 8'hFE, 0, 0);
      run_instr(8'h10, 8'h9C, 8'h00, 3, 0);
   endtask

   task automatic test_index;
      run_instr(8'h50, 8'h00, 8'h00, 0, 0);
      run_instr(8'h3E, 8'h00, 8'h00, 0, 0);
      run_instr(8'h15, 8'h07, 8'h00, 0, 0);
      run_instr(8'h2D, 8'h00, 8'h00, 0, 0);
   endtask

   task automatic test_conv_illegal;
      run_instr(8'h91, 8'h00, 8'h00, 0, 0);
      run_instr(8'hCA, 8'h00, 8'h00, 0, 0);
   endtask

   task automatic test_async_reset;
      offer(8'h11);
      offer(8'h80);
      #2 reset = 1'b1;
      #1;
      total++;
      if (ready_from_decoder !== 1'b1 || decode_valid !== 1'b0) begin
         bad++; $display("FAIL async_reset_hs ready=%b valid=%b want 1/0", ready_from_decoder, decode_valid);
      end
      total++;
      if ({opcode, op_class, index, const_value, illegal} !== '0) begin
         bad++; $display("FAIL async_reset_outputs op=%02h cls=%0d ill=%b want 0", opcode, op_class, illegal);
      end
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      total++;
      if (decode_valid !== 1'b0) begin
         bad++; $display("FAIL async_reset_valid got=%b want=0", decode_valid);
      end
      @(posedge clk); #1;
      run_instr(8'h00, 8'h00, 8'h00, 0, 0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(2)) @(posedge clk);
         #1;
         run_instr(8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)),
                   int'($urandom_range(2)), 1'($urandom_range(1)));
      end
   endtask

   initial begin
      #1;
      test_reset;
      test_iconst;
      test_div_latency;
      test_multibyte;
      test_index;
      test_conv_illegal;
      test_async_reset;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

endmodule
